ps2_scan_rx: RTL and testbench

//  Parametrised PS/2 keyboard receiver. Successor to the fixed-width capture/display path.
//  - Oversamples ps2clk/ps2data in the fpgaclk domain and frames 11-bit packets.
//  - Checks start, parity and stop bits; aborts stalled frames on a timeout.
//  - Folds E0/F0 prefixes into one code event, and keeps a DEPTH-entry make-code history

---
 rtl/ps2_scan_rx.sv | 195 +++++++++++++++++++
 tb/tb_ps2_scan_rx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 keyboard receiver with glitch filter, frame checks, E0/F0 folding and
// a make-code history. Define PS2_PARITY_CHK_EN to treat a parity mismatch as a frame error.
module ps2_scan_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 50000,
   parameter int DEPTH       = 6
) (
   input  logic                       fpgaclk,
   input  logic                       rst,
   input  logic                       ps2clk,
   input  logic                       ps2data,
   output logic                       code_valid,
   output logic [7:0]                 code,
   output logic                       code_break,
   output logic                       code_ext,
   output logic                       frame_err,
   output logic [8*DEPTH-1:0]         history,
   output logic [$clog2(DEPTH+1)-1:0] hist_count
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int HW = $clog2(DEPTH + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DATA   = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;
   localparam logic [1:0] STOP   = 2'd3;

   logic [SYNC_STAGES-1:0] clk_sync_reg;
   logic [SYNC_STAGES-1:0] data_sync_reg;
   logic                   clk_f_reg;
   logic                   clk_f_d_reg;
   logic [FW-1:0]          filt_cnt_reg;
   logic                   fall_reg;
   logic [1:0]             state_reg;
   logic [2:0]             bitcnt_reg;
   logic [7:0]             shift_reg;
   logic [TW-1:0]          to_cnt_reg;
   logic                   ext_reg;
   logic                   brk_reg;
   logic [7:0]             hist_reg [DEPTH];
   logic                   clk_s;
   logic                   data_s;
   logic                   frame_ok;
   logic                   make_evt;
`ifdef PS2_PARITY_CHK_EN
   logic                   parity_reg;
`endif

   assign clk_s  = clk_sync_reg[SYNC_STAGES-1];
   assign data_s = data_sync_reg[SYNC_STAGES-1];

   always_ff @(posedge fpgaclk or negedge rst) begin
      if (!rst) begin
         clk_sync_reg  <= '0;
         data_sync_reg <= '0;
      end else begin
         clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2clk};
         data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2data};
      end
   end

   // clk_f only follows the line after FILTER_LEN consecutive disagreeing samples
   always_ff @(posedge fpgaclk or negedge rst) begin
      if (!rst) begin
         clk_f_reg    <= 1'b1;
         clk_f_d_reg  <= 1'b0;
         filt_cnt_reg <= '0;
         fall_reg     <= 1'b0;
      end else begin
         clk_f_d_reg <= clk_f_reg;
         fall_reg    <= clk_f_d_reg & ~clk_f_reg;
         if (clk_s != clk_f_reg) begin
            if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
               clk_f_reg    <= clk_s;
               filt_cnt_reg <= '0;
            end else begin
               filt_cnt_reg <= filt_cnt_reg + 1'b1;
            end
         end else begin
            filt_cnt_reg <= '0;
         end
      end
   end

`ifdef PS2_PARITY_CHK_EN
   assign frame_ok = data_s & (^{shift_reg, parity_reg});
`else
   assign frame_ok = data_s;
`endif

   assign make_evt = fall_reg && (state_reg == STOP) && frame_ok && !brk_reg &&
                     (shift_reg != 8'hE0) && (shift_reg != 8'hF0);

   always_ff @(posedge fpgaclk or negedge rst) begin
      if (!rst) begin
         state_reg  <= IDLE;
         bitcnt_reg <= '0;
         shift_reg  <= '0;
         to_cnt_reg <= '0;
         ext_reg    <= 1'b0;
         brk_reg    <= 1'b0;
         code_valid <= 1'b0;
         code       <= '0;
         code_break <= 1'b0;
         code_ext   <= 1'b0;
         frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHK_EN
         parity_reg <= 1'b0;
`endif
      end else begin
         code_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (fall_reg || state_reg == IDLE) begin
            to_cnt_reg <= '0;
         end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
         end
         if (fall_reg) begin
            case (state_reg)
               IDLE: begin
                  if (!data_s) begin
                     state_reg  <= DATA;
                     bitcnt_reg <= '0;
                  end
               end
               DATA: begin
                  shift_reg  <= {data_s, shift_reg[7:1]};
                  bitcnt_reg <= bitcnt_reg + 1'b1;
                  if (bitcnt_reg == 3'd7) begin
                     state_reg <= PARITY;
                  end
               end
               PARITY: begin
`ifdef PS2_PARITY_CHK_EN
                  parity_reg <= data_s;
`endif
                  state_reg <= STOP;
               end
               default: begin
                  state_reg <= IDLE;
                  if (!frame_ok) begin
                     frame_err <= 1'b1;
                     ext_reg   <= 1'b0;
                     brk_reg   <= 1'b0;
                  end else if (shift_reg == 8'hE0) begin
                     ext_reg <= 1'b1;
                  end else if (shift_reg == 8'hF0) begin
                     brk_reg <= 1'b1;
                  end else begin
                     code_valid <= 1'b1;
                     code       <= shift_reg;
                     code_break <= brk_reg;
                     code_ext   <= ext_reg;
                     ext_reg    <= 1'b0;
                     brk_reg    <= 1'b0;
                  end
               end
            endcase
         end else if (state_reg != IDLE && to_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
            // a fall in this same cycle takes the branch above and keeps the frame alive
            state_reg <= IDLE;
            frame_err <= 1'b1;
            ext_reg   <= 1'b0;
            brk_reg   <= 1'b0;
         end
      end
   end

   always_ff @(posedge fpgaclk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            hist_reg[i] <= '0;
         end
         hist_count <= '0;
      end else if (make_evt) begin
         hist_reg[0] <= shift_reg;
         for (int i = 1; i < DEPTH; i++) begin
            hist_reg[i] <= hist_reg[i-1];
         end
         if (hist_count != HW'(DEPTH)) begin
            hist_count <= hist_count + 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_hist
         assign history[8*gi +: 8] = hist_reg[gi];
      end
   endgenerate

endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb_ps2_scan_rx: drives PS/2 frames (directed and random) into ps2_scan_rx and checks
// decoded events, frame errors and history against a queue-based keyboard model.
module tb_ps2_scan_rx;
   localparam int DEPTH = 6;
   localparam int TOC   = 400;
   localparam int HALF  = 20;
`ifdef PS2_PARITY_CHK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic                       fpgaclk = 1'b0;
   logic                       rst     = 1'b0;
   logic                       ps2clk  = 1'b1;
   logic                       ps2data = 1'b1;
   logic                       code_valid;
   logic [7:0]                 code;
   logic                       code_break;
   logic                       code_ext;
   logic                       frame_err;
   logic [8*DEPTH-1:0]         history;
   logic [$clog2(DEPTH+1)-1:0] hist_count;

   int checks = 0;
   int errors = 0;

   always #5 fpgaclk = ~fpgaclk;

   ps2_scan_rx #(
      .SYNC_STAGES(2),
      .FILTER_LEN (4),
      .TIMEOUT_CYC(TOC),
      .DEPTH      (DEPTH)
   ) dut (
      .fpgaclk   (fpgaclk),
      .rst       (rst),
      .ps2clk    (ps2clk),
      .ps2data   (ps2data),
      .code_valid(code_valid),
      .code      (code),
      .code_break(code_break),
      .code_ext  (code_ext),
      .frame_err (frame_err),
      .history   (history),
      .hist_count(hist_count)
   );

   typedef struct packed {
      logic [7:0] c;
      logic       b;
      logic       e;
   } ev_t;

   // observed strobes, captured on the falling edge
   ev_t evq[$];
   int  nerr  = 0;
   int  nboth = 0;

   always @(negedge fpgaclk) begin
      if (code_valid) evq.push_back({code, code_break, code_ext});
      if (frame_err) nerr++;
      if (code_valid && frame_err) nboth++;
   end

   // keyboard model: prefix flags, expected events, newest-first history
   bit         m_ext = 1'b0;
   bit         m_brk = 1'b0;
   logic [7:0] m_hist[$];
   ev_t        exp_q[$];
   int         exp_err = 0;

   function automatic void model_byte(input logic [7:0] b, input bit bad);
      if (bad) begin
         exp_err++;
         m_ext = 1'b0;
         m_brk = 1'b0;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         exp_q.push_back({b, m_brk, m_ext});
         if (!m_brk) begin
            m_hist.push_front(b);
            if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge fpgaclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // nbits < 11 sends a truncated frame; glitch adds a 1-cycle low pulse before bit 3
   task automatic send(input logic [7:0] b, input bit flip, input bit badstop,
                       input int nbits, input bit glitch);
      logic [10:0] bits;
      bits = {~badstop, (~^b) ^ flip, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2data = bits[i];
         if (glitch && i == 3) begin
            tick(HALF / 2);
            ps2clk = 1'b0;
            tick(1);
            ps2clk = 1'b1;
            tick(HALF - HALF / 2 - 1);
         end else begin
            tick(HALF);
         end
         ps2clk = 1'b0;
         tick(HALF);
         ps2clk = 1'b1;
      end
      tick(2);
      ps2data = 1'b1;
      tick(HALF);
   endtask

   task automatic xmit(input logic [7:0] b, input bit flip, input bit badstop, input bit glitch);
      send(b, flip, badstop, 11, glitch);
      model_byte(b, badstop || (flip && PAR_EN));
   endtask

   task automatic compare(input string tag);
      logic [47:0] eh;
      ev_t         o;
      ev_t         e;
      int          n_obs;
      tick(12);
      n_obs = evq.size();
      check({tag, ":n_events"}, 64'(evq.size()), 64'(exp_q.size()));
      while (evq.size() > 0 && exp_q.size() > 0) begin
         o = evq.pop_front();
         e = exp_q.pop_front();
         check({tag, ":code"}, 64'(o.c), 64'(e.c));
         check({tag, ":code_break"}, 64'(o.b), 64'(e.b));
         check({tag, ":code_ext"}, 64'(o.e), 64'(e.e));
      end
      evq.delete();
      exp_q.delete();
      check({tag, ":frame_err_count"}, 64'(nerr), 64'(exp_err));
      nerr    = 0;
      exp_err = 0;
      eh = '0;
      foreach (m_hist[i]) eh[8*i +: 8] = m_hist[i];
      check({tag, ":history"}, 64'(history), 64'(eh));
      check({tag, ":hist_count"}, 64'(hist_count), 64'(m_hist.size()));
      $display("txn %s events=%0d hist_count=%0d history=%h", tag, n_obs, hist_count, history);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ":code_valid"}, 64'(code_valid), 64'd0);
      check({tag, ":frame_err"}, 64'(frame_err), 64'd0);
      check({tag, ":code"}, 64'(code), 64'd0);
      check({tag, ":flags"}, 64'({code_break, code_ext}), 64'd0);
      check({tag, ":history"}, 64'(history), 64'd0);
      check({tag, ":hist_count"}, 64'(hist_count), 64'd0);
   endtask

   initial begin
      logic [7:0] rb;
      int         kind;
      bit         corrupt;

      tick(5);
      check_all_zero("reset");
      rst = 1'b1;
      tick(20);
      evq.delete();
      nerr = 0;

      xmit(8'h1C, 1'b0, 1'b0, 1'b0);
      compare("make_1C");
      check("make_1C:hist0", 64'(history[7:0]), 64'h1C);
      check("make_1C:count1", 64'(hist_count), 64'd1);

      xmit(8'hF0, 1'b0, 1'b0, 1'b0);
      xmit(8'h1C, 1'b0, 1'b0, 1'b0);
      compare("break_1C");

      xmit(8'hE0, 1'b0, 1'b0, 1'b0);
      xmit(8'h75, 1'b0, 1'b0, 1'b0);
      compare("ext_make_75");
      xmit(8'hE0, 1'b0, 1'b0, 1'b0);
      xmit(8'hF0, 1'b0, 1'b0, 1'b0);
      xmit(8'h75, 1'b0, 1'b0, 1'b0);
      compare("ext_break_75");

      xmit(8'h1C, 1'b1, 1'b0, 1'b0);
      compare("parity_flip_1C");
      xmit(8'h1C, 1'b0, 1'b1, 1'b0);
      compare("bad_stop_1C");
      xmit(8'hE0, 1'b0, 1'b0, 1'b0);
      xmit(8'h24, 1'b0, 1'b1, 1'b0);
      xmit(8'h24, 1'b0, 1'b0, 1'b0);
      compare("error_clears_ext");

      // stall after 4 data bits: one timeout error, then a clean frame
      send(8'h55, 1'b0, 1'b0, 5, 1'b0);
      tick(TOC + 40);
      model_byte(8'h00, 1'b1);
      compare("timeout");
      xmit(8'h2A, 1'b0, 1'b0, 1'b0);
      compare("after_timeout_2A");

      for (int k = 0; k < DEPTH + 2; k++) begin
         xmit(8'h40 + 8'(k), 1'b0, 1'b0, (k == 3));
      end
      compare("history_fill");
      check("history_fill:saturated", 64'(hist_count), 64'(DEPTH));
      check("history_fill:newest", 64'(history[7:0]), 64'h40 + 64'(DEPTH + 1));

      for (int g = 0; g < 20; g++) begin
         do rb = 8'($urandom_range(1, 255)); while (rb == 8'hE0 || rb == 8'hF0);
         kind    = int'($urandom_range(0, 3));
         corrupt = ($urandom_range(0, 5) == 0);
         if (kind == 2 || kind == 3) xmit(8'hE0, 1'b0, 1'b0, 1'b0);
         if (kind == 1 || kind == 3) xmit(8'hF0, 1'b0, 1'b0, 1'b0);
         xmit(rb, corrupt && $urandom_range(0, 1) == 0, 1'b0, $urandom_range(0, 3) == 0);
         compare($sformatf("rand%0d_k%0d_%h", g, kind, rb));
      end

      // reset in the middle of a frame wipes everything
      send(8'h66, 1'b0, 1'b0, 5, 1'b0);
      rst = 1'b0;
      tick(3);
      check_all_zero("mid_reset");
      m_hist.delete();
      exp_q.delete();
      m_ext   = 1'b0;
      m_brk   = 1'b0;
      exp_err = 0;
      ps2clk  = 1'b1;
      ps2data = 1'b1;
      rst     = 1'b1;
      tick(20);
      evq.delete();
      nerr = 0;
      xmit(8'h33, 1'b0, 1'b0, 1'b0);
      compare("after_reset_33");

      check("strobes_exclusive", 64'(nboth), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
